// File: rtl/vend_controller.sv
//------------------------------------------------------------------------------
// vend_controller : coin-credit vending FSM with per-slot price/stock tables
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module vend_controller #(
   parameter int NUM_SLOTS   = 8,
   parameter int STOCK_W     = 5,
   parameter int INIT_STOCK  = 10,
   parameter int LOW_THRESH  = 5,
   parameter int MAX_CREDIT  = 20000,
   parameter int TIMEOUT_CYC = 255,
   parameter int SID_W       = $clog2(NUM_SLOTS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               coin_valid,
   input  logic [1:0]         coin_type,
   input  logic               sel_valid,
   input  logic [SID_W-1:0]   sel_id,
   input  logic               cancel,
   input  logic               price_wr_en,
   input  logic [SID_W-1:0]   price_wr_id,
   input  logic [15:0]        price_wr_data,
   input  logic               restock_valid,
   input  logic [SID_W-1:0]   restock_id,
   input  logic [STOCK_W-1:0] restock_qty,
   input  logic               dispense_ready,
   input  logic               change_ready,
   output logic [1:0]         state,
   output logic [15:0]        credit,
   output logic               dispense_valid,
   output logic [SID_W-1:0]   dispense_id,
   output logic               change_valid,
   output logic [15:0]        change_amount,
   output logic [STOCK_W-1:0] stock_level,
   output logic               low_stock,
   output logic               coin_reject,
   output logic               err_sold_out,
   output logic               err_funds,
   output logic               timeout,
   output logic [15:0]        sales_count
);

   localparam int DEPTH = 1 << SID_W;
   localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_CREDIT = 2'b01;
   localparam logic [1:0] S_VEND   = 2'b10;
   localparam logic [1:0] S_CHANGE = 2'b11;

   localparam logic [SID_W:0]   C_NSLOTS   = (SID_W + 1)'(NUM_SLOTS);
   localparam logic [16:0]      C_MAX_CR   = 17'(MAX_CREDIT);
   localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [31:0]      C_LOW      = 32'(LOW_THRESH);

   logic [1:0]         state_q, state_d;
   logic [15:0]        credit_q, credit_d;
   logic [15:0]        sales_q, sales_d;
   logic [SID_W-1:0]   disp_id_q, disp_id_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic               coin_reject_q, coin_reject_d;
   logic               err_sold_out_q, err_sold_out_d;
   logic               err_funds_q, err_funds_d;
   logic               timeout_q, timeout_d;
   logic [STOCK_W-1:0] stock_q [DEPTH];
   logic [STOCK_W-1:0] stock_d [DEPTH];
   logic [15:0]        price_q [DEPTH];
   logic [15:0]        price_d [DEPTH];

   logic [15:0]        coin_val;
   logic [16:0]        credit_sum;
   logic               coin_fits;
   logic               sel_id_ok;
   logic [STOCK_W-1:0] sel_stock;
   logic [15:0]        sel_price;
   logic [STOCK_W:0]   restock_sum;

   always_comb begin
      coin_val = 16'd500;
      case (coin_type)
         2'b00:   coin_val = 16'd500;
         2'b01:   coin_val = 16'd1000;
         2'b10:   coin_val = 16'd2000;
         default: coin_val = 16'd5000;
      endcase
   end

   assign credit_sum  = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_fits   = (credit_sum <= C_MAX_CR);
   assign sel_id_ok   = ({1'b0, sel_id} < C_NSLOTS);
   assign sel_stock   = stock_q[sel_id];
   assign sel_price   = price_q[sel_id];
   assign restock_sum = {1'b0, stock_q[restock_id]} + {1'b0, restock_qty};

   // State register and all datapath flops; slots past NUM_SLOTS stay empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         credit_q       <= '0;
         sales_q        <= '0;
         disp_id_q      <= '0;
         tmo_cnt_q      <= '0;
         coin_reject_q  <= 1'b0;
         err_sold_out_q <= 1'b0;
         err_funds_q    <= 1'b0;
         timeout_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stock_q[i] <= (i < NUM_SLOTS) ? STOCK_W'(INIT_STOCK) : '0;
            price_q[i] <= (i < NUM_SLOTS) ? 16'(500 * (i + 1)) : '0;
         end
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         sales_q        <= sales_d;
         disp_id_q      <= disp_id_d;
         tmo_cnt_q      <= tmo_cnt_d;
         coin_reject_q  <= coin_reject_d;
         err_sold_out_q <= err_sold_out_d;
         err_funds_q    <= err_funds_d;
         timeout_q      <= timeout_d;
         stock_q        <= stock_d;
         price_q        <= price_d;
      end
   end

   // Next-state and datapath update; the timeout counter only runs on idle CREDIT cycles.
   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      sales_d        = sales_q;
      disp_id_d      = disp_id_q;
      tmo_cnt_d      = '0;
      coin_reject_d  = 1'b0;
      err_sold_out_d = 1'b0;
      err_funds_d    = 1'b0;
      timeout_d      = 1'b0;
      stock_d        = stock_q;
      price_d        = price_q;

      case (state_q)
         S_IDLE: begin
            if (coin_valid) begin
               if (coin_fits) begin
                  credit_d = credit_sum[15:0];
                  state_d  = S_CREDIT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
            if (price_wr_en && ({1'b0, price_wr_id} < C_NSLOTS)) begin
               price_d[price_wr_id] = price_wr_data;
            end
            if (restock_valid && ({1'b0, restock_id} < C_NSLOTS)) begin
               stock_d[restock_id] = restock_sum[STOCK_W] ? {STOCK_W{1'b1}}
                                                          : restock_sum[STOCK_W-1:0];
            end
         end
         S_CREDIT: begin
            if (cancel) begin
               state_d = S_CHANGE;
            end else if (coin_valid) begin
               if (coin_fits) begin
                  credit_d = credit_sum[15:0];
               end else begin
                  coin_reject_d = 1'b1;
               end
            end else if (sel_valid) begin
               if (!sel_id_ok || (sel_stock == '0)) begin
                  err_sold_out_d = 1'b1;
               end else if (credit_q < sel_price) begin
                  err_funds_d = 1'b1;
               end else begin
                  credit_d         = credit_q - sel_price;
                  stock_d[sel_id]  = sel_stock - 1'b1;
                  sales_d          = (sales_q == 16'hFFFF) ? sales_q : sales_q + 16'd1;
                  disp_id_d        = sel_id;
                  state_d          = S_VEND;
               end
            end else if (tmo_cnt_q == C_TMO_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_CHANGE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         S_VEND: begin
            coin_reject_d = coin_valid;
            if (dispense_ready) begin
               state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
         end
         default: begin
            coin_reject_d = coin_valid;
            if (change_ready) begin
               credit_d = '0;
               state_d  = S_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      state          = state_q;
      credit         = credit_q;
      dispense_valid = (state_q == S_VEND);
      dispense_id    = disp_id_q;
      change_valid   = (state_q == S_CHANGE);
      change_amount  = (state_q == S_CHANGE) ? credit_q : 16'd0;
      stock_level    = sel_stock;
      low_stock      = ({{(32 - STOCK_W){1'b0}}, sel_stock} < C_LOW);
      coin_reject    = coin_reject_q;
      err_sold_out   = err_sold_out_q;
      err_funds      = err_funds_q;
      timeout        = timeout_q;
      sales_count    = sales_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_vend_controller.sv
//------------------------------------------------------------------------------
// tb_vend_controller : directed self-checking bench for vend_controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vend_controller;

   localparam int SID_W   = 3;
   localparam int STOCK_W = 5;

   logic               clk;
   logic               reset;
   logic               coin_valid;
   logic [1:0]         coin_type;
   logic               sel_valid;
   logic [SID_W-1:0]   sel_id;
   logic               cancel;
   logic               price_wr_en;
   logic [SID_W-1:0]   price_wr_id;
   logic [15:0]        price_wr_data;
   logic               restock_valid;
   logic [SID_W-1:0]   restock_id;
   logic [STOCK_W-1:0] restock_qty;
   logic               dispense_ready;
   logic               change_ready;
   logic [1:0]         state;
   logic [15:0]        credit;
   logic               dispense_valid;
   logic [SID_W-1:0]   dispense_id;
   logic               change_valid;
   logic [15:0]        change_amount;
   logic [STOCK_W-1:0] stock_level;
   logic               low_stock;
   logic               coin_reject;
   logic               err_sold_out;
   logic               err_funds;
   logic               timeout;
   logic [15:0]        sales_count;

   int errors = 0;
   int checks = 0;

   vend_controller dut (
      .clk(clk), .reset(reset),
      .coin_valid(coin_valid), .coin_type(coin_type),
      .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
      .price_wr_en(price_wr_en), .price_wr_id(price_wr_id), .price_wr_data(price_wr_data),
      .restock_valid(restock_valid), .restock_id(restock_id), .restock_qty(restock_qty),
      .dispense_ready(dispense_ready), .change_ready(change_ready),
      .state(state), .credit(credit),
      .dispense_valid(dispense_valid), .dispense_id(dispense_id),
      .change_valid(change_valid), .change_amount(change_amount),
      .stock_level(stock_level), .low_stock(low_stock),
      .coin_reject(coin_reject), .err_sold_out(err_sold_out),
      .err_funds(err_funds), .timeout(timeout), .sales_count(sales_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic [1:0] t);
      coin_valid = 1'b1;
      coin_type  = t;
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic sel(input logic [SID_W-1:0] id);
      sel_valid = 1'b1;
      sel_id    = id;
      tick();
      sel_valid = 1'b0;
   endtask

   task automatic do_cancel;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   task automatic pay_out;
      change_ready = 1'b1;
      tick();
      change_ready = 1'b0;
   endtask

   task automatic take_item;
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;         coin_valid = 1'b0;    coin_type = 2'b00;
      sel_valid = 1'b0;     sel_id = '0;          cancel = 1'b0;
      price_wr_en = 1'b0;   price_wr_id = '0;     price_wr_data = '0;
      restock_valid = 1'b0; restock_id = '0;      restock_qty = '0;
      dispense_ready = 1'b0; change_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_state", 32'(state), 32'd0);
      chk("rst_credit", 32'(credit), 32'd0);
      chk("rst_dvalid", 32'(dispense_valid), 32'd0);
      chk("rst_cvalid", 32'(change_valid), 32'd0);
      chk("rst_sales", 32'(sales_count), 32'd0);
      chk("rst_stock", 32'(stock_level), 32'd10);
      chk("rst_low", 32'(low_stock), 32'd0);

      // Coins 500, 500, 1000 then slot 1 (price 1000)
      coin(2'b00);
      chk("c1_state", 32'(state), 32'd1);
      chk("c1_credit", 32'(credit), 32'd500);
      coin(2'b00);
      coin(2'b01);
      chk("c3_credit", 32'(credit), 32'd2000);
      sel(3'd1);
      chk("v1_state", 32'(state), 32'd2);
      chk("v1_dvalid", 32'(dispense_valid), 32'd1);
      chk("v1_did", 32'(dispense_id), 32'd1);
      chk("v1_credit", 32'(credit), 32'd1000);
      chk("v1_sales", 32'(sales_count), 32'd1);
      chk("v1_stock", 32'(stock_level), 32'd9);
      tick();
      chk("v1_hold", 32'(dispense_valid), 32'd1);
      coin(2'b10);
      chk("vend_coin_rej", 32'(coin_reject), 32'd1);
      chk("vend_coin_credit", 32'(credit), 32'd1000);
      tick();
      chk("rej_pulse_end", 32'(coin_reject), 32'd0);
      take_item();
      chk("v1_chg_state", 32'(state), 32'd3);
      chk("v1_chg_valid", 32'(change_valid), 32'd1);
      chk("v1_chg_amt", 32'(change_amount), 32'd1000);
      tick();
      chk("v1_chg_hold", 32'(change_valid), 32'd1);
      pay_out();
      chk("v1_idle", 32'(state), 32'd0);
      chk("v1_credit0", 32'(credit), 32'd0);
      chk("v1_cvalid0", 32'(change_valid), 32'd0);

      // Credit ceiling
      repeat (4) coin(2'b11);
      chk("max_credit", 32'(credit), 32'd20000);
      coin(2'b00);
      chk("max_rej", 32'(coin_reject), 32'd1);
      chk("max_keep", 32'(credit), 32'd20000);
      chk("max_state", 32'(state), 32'd1);
      do_cancel();
      chk("cancel_state", 32'(state), 32'd3);
      chk("cancel_amt", 32'(change_amount), 32'd20000);
      pay_out();

      // Insufficient funds on slot 3 (price 2000)
      coin(2'b00);
      sel(3'd3);
      chk("funds_err", 32'(err_funds), 32'd1);
      chk("funds_state", 32'(state), 32'd1);
      chk("funds_credit", 32'(credit), 32'd500);
      chk("funds_stock", 32'(stock_level), 32'd10);
      tick();
      chk("funds_pulse_end", 32'(err_funds), 32'd0);

      // Cancel beats coin and select in the same cycle
      coin_valid = 1'b1; coin_type = 2'b00; sel_valid = 1'b1; sel_id = 3'd0; cancel = 1'b1;
      tick();
      coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
      chk("prio_state", 32'(state), 32'd3);
      chk("prio_credit", 32'(credit), 32'd500);
      chk("prio_sales", 32'(sales_count), 32'd1);
      chk("prio_norej", 32'(coin_reject), 32'd0);
      chk("prio_stock", 32'(stock_level), 32'd10);
      pay_out();

      // Drain slot 0 (price 500) through the low-stock threshold to empty
      for (int k = 1; k <= 10; k++) begin
         coin(2'b00);
         sel(3'd0);
         take_item();
         chk("drain_state", 32'(state), 32'd0);
         chk("drain_stock", 32'(stock_level), 32'(10 - k));
         chk("drain_low", 32'(low_stock), ((10 - k) < 5) ? 32'd1 : 32'd0);
      end
      coin(2'b00);
      sel(3'd0);
      chk("sold_out", 32'(err_sold_out), 32'd1);
      chk("sold_state", 32'(state), 32'd1);
      chk("sold_stock", 32'(stock_level), 32'd0);
      chk("sold_low", 32'(low_stock), 32'd1);
      chk("sold_sales", 32'(sales_count), 32'd11);
      do_cancel();
      pay_out();
      restock_valid = 1'b1; restock_id = 3'd0; restock_qty = 5'd31;
      tick();
      chk("restock31", 32'(stock_level), 32'd31);
      restock_qty = 5'd5;
      tick();
      restock_valid = 1'b0;
      chk("restock_sat", 32'(stock_level), 32'd31);

      // Price rewrite for slot 2
      price_wr_en = 1'b1; price_wr_id = 3'd2; price_wr_data = 16'd700;
      tick();
      price_wr_en = 1'b0;
      coin(2'b01);
      sel(3'd2);
      chk("newprice_state", 32'(state), 32'd2);
      chk("newprice_credit", 32'(credit), 32'd300);
      chk("newprice_did", 32'(dispense_id), 32'd2);
      take_item();
      chk("newprice_chg", 32'(change_amount), 32'd300);
      pay_out();

      // Idle timeout after one coin
      coin(2'b00);
      repeat (254) tick();
      chk("tmo_pre_state", 32'(state), 32'd1);
      chk("tmo_pre_pulse", 32'(timeout), 32'd0);
      tick();
      chk("tmo_pulse", 32'(timeout), 32'd1);
      chk("tmo_state", 32'(state), 32'd3);
      chk("tmo_amt", 32'(change_amount), 32'd500);
      tick();
      chk("tmo_pulse_end", 32'(timeout), 32'd0);
      pay_out();

      // Reset aborts a vend and a payout
      coin(2'b00);
      sel(3'd0);
      chk("abort_vend_state", 32'(state), 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_vend_idle", 32'(state), 32'd0);
      chk("abort_vend_dvalid", 32'(dispense_valid), 32'd0);
      chk("abort_vend_credit", 32'(credit), 32'd0);
      chk("abort_vend_sales", 32'(sales_count), 32'd0);
      chk("abort_vend_stock", 32'(stock_level), 32'd10);
      coin(2'b01);
      do_cancel();
      chk("abort_chg_state", 32'(state), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_chg_cvalid", 32'(change_valid), 32'd0);
      chk("abort_chg_credit", 32'(credit), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
